// File: rtl/shwr_summary_buf_pkg.sv
// Shared definitions for the shower summary buffer.
//   - capture FSM state encoding
//   - default integration window length and upstream settle margin
//   - summary record field layout (MSB..LSB):
//       {INTEGRAL, PEAK, BASELINE, SATURATED, EARLY, TAG}
package shwr_summary_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    HOLD
  } shwr_state_t;

  // Integration window length in bins; must match the integral stage.
  localparam int unsigned SHWR_AREA_BINS     = 255;
  // Window plus two-stage integral pipeline plus one bin of margin.
  localparam int unsigned SHWR_SETTLE_MARGIN = 3;

  localparam int unsigned SHWR_TAG_WIDTH  = 8;
  localparam int unsigned SHWR_DROP_WIDTH = 8;
  // SATURATED and EARLY flags.
  localparam int unsigned SHWR_FLAG_BITS  = 2;

  function automatic int unsigned shwr_rec_width(input int unsigned area_w,
                                                 input int unsigned adc_w,
                                                 input int unsigned base_w);
    return area_w + adc_w + base_w + SHWR_FLAG_BITS + SHWR_TAG_WIDTH;
  endfunction

endpackage

// File: rtl/shwr_fwft_fifo.sv
// First-word-fall-through FIFO for shower summary records.
//   CLK120     clock, rising edge
//   RESET      asynchronous active-high reset (pointers/flags; storage kept)
//   PUSH       write PUSH_DATA; accepted when not FULL or when popping
//   PUSH_DATA  record to store
//   POP        remove head record; ignored when EMPTY
//   POP_DATA   head record (valid while EMPTY=0)
//   COUNT      records stored, 0..2**DEPTH_LOG2
//   FULL       registered, COUNT == depth
//   EMPTY      registered, COUNT == 0
module shwr_fwft_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  CLK120,
  input  logic                  RESET,
  input  logic                  PUSH,
  input  logic [WIDTH-1:0]      PUSH_DATA,
  input  logic                  POP,
  output logic [WIDTH-1:0]      POP_DATA,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;
  logic [DEPTH_LOG2:0]   count_next;

  // A pop in the same cycle frees the slot, so a push while FULL still lands.
  assign pop_ok  = POP & ~EMPTY;
  assign push_ok = PUSH & (~FULL | pop_ok);

  assign POP_DATA = mem[rd_ptr];

  always_comb begin
    count_next = COUNT;
    if (push_ok && !pop_ok) count_next = COUNT + 1'b1;
    else if (!push_ok && pop_ok) count_next = COUNT - 1'b1;
  end

  always_ff @(posedge CLK120) begin
    if (push_ok) mem[wr_ptr] <= PUSH_DATA;
  end

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      FULL   <= 1'b0;
      EMPTY  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      COUNT <= count_next;
      FULL  <= (count_next == CW'(DEPTH));
      EMPTY <= (count_next == '0);
    end
  end

endmodule

// File: rtl/shwr_summary_buf.sv
// Per-PMT shower summary capture. Watches the shower trigger window, and once
// the integral stage has settled (or the window ends early) pushes one
// {INTEGRAL, PEAK, BASELINE, SATURATED, EARLY, TAG} record into a small FWFT
// FIFO drained by the processor register interface.
//   CLK120, RESET                 clock / asynchronous active-high reset
//   TRIGGERED                     shower trigger window
//   INTEGRAL, PEAK, BASELINE,
//   SATURATED                     upstream integral-stage results
//   RD_EN                         pop head record (ignored when EMPTY)
//   OUT_*                         head record fields (0 while EMPTY)
//   EMPTY, FULL, COUNT            FIFO status
//   DROPPED                       saturating count of records lost to FULL
module shwr_summary_buf
  import shwr_summary_buf_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 12,
  parameter int unsigned BASE_WIDTH = 14,
  parameter int unsigned AREA_WIDTH = 19,
  parameter int unsigned AREA_BINS  = SHWR_AREA_BINS,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                       CLK120,
  input  logic                       RESET,
  input  logic                       TRIGGERED,
  input  logic [AREA_WIDTH-1:0]      INTEGRAL,
  input  logic [ADC_WIDTH-1:0]       PEAK,
  input  logic [BASE_WIDTH-1:0]      BASELINE,
  input  logic                       SATURATED,
  input  logic                       RD_EN,
  output logic [AREA_WIDTH-1:0]      OUT_INTEGRAL,
  output logic [ADC_WIDTH-1:0]       OUT_PEAK,
  output logic [BASE_WIDTH-1:0]      OUT_BASELINE,
  output logic                       OUT_SAT,
  output logic                       OUT_EARLY,
  output logic [SHWR_TAG_WIDTH-1:0]  OUT_TAG,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [DEPTH_LOG2:0]        COUNT,
  output logic [SHWR_DROP_WIDTH-1:0] DROPPED
);

  localparam int unsigned REC_W = shwr_rec_width(AREA_WIDTH, ADC_WIDTH, BASE_WIDTH);
  localparam int unsigned DONE  = AREA_BINS + SHWR_SETTLE_MARGIN;
  localparam int unsigned CNT_W = $clog2(DONE + 1);

  shwr_state_t               state;
  logic [CNT_W-1:0]          bin_cnt;
  logic                      armed;
  logic [SHWR_TAG_WIDTH-1:0] tag;
  logic                      push;
  logic                      early;
  logic                      drop;
  logic [REC_W-1:0]          push_data;
  logic [REC_W-1:0]          head;

  logic [AREA_WIDTH-1:0]     head_integral;
  logic [ADC_WIDTH-1:0]      head_peak;
  logic [BASE_WIDTH-1:0]     head_baseline;
  logic                      head_sat;
  logic                      head_early;
  logic [SHWR_TAG_WIDTH-1:0] head_tag;

  // Push is decided combinationally from the FSM state so the record samples
  // upstream values on the very edge TRIGGERED is seen low.
  always_comb begin
    push  = 1'b0;
    early = 1'b0;
    if (state == INTEG) begin
      if (bin_cnt == CNT_W'(DONE)) begin
        push = 1'b1;
      end else if (!TRIGGERED) begin
        push  = 1'b1;
        early = 1'b1;
      end
    end
  end

  // FULL implies non-empty, so any RD_EN that cycle frees a slot.
  assign drop      = push & FULL & ~RD_EN;
  assign push_data = {INTEGRAL, PEAK, BASELINE, SATURATED, early, tag};

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      bin_cnt <= '0;
      armed   <= 1'b0;
      tag     <= '0;
      DROPPED <= '0;
    end else begin
      // A window cut by reset must not re-arm until TRIGGERED has dropped.
      if (!TRIGGERED) armed <= 1'b1;
      if (push) tag <= tag + 1'b1;
      if (drop && DROPPED != '1) DROPPED <= DROPPED + 1'b1;
      case (state)
        IDLE: begin
          if (TRIGGERED && armed) begin
            state   <= INTEG;
            bin_cnt <= '0;
          end
        end
        INTEG: begin
          bin_cnt <= bin_cnt + 1'b1;
          if (bin_cnt == CNT_W'(DONE)) state <= TRIGGERED ? HOLD : IDLE;
          else if (!TRIGGERED)         state <= IDLE;
        end
        HOLD: begin
          if (!TRIGGERED) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  shwr_fwft_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK120    (CLK120),
    .RESET     (RESET),
    .PUSH      (push),
    .PUSH_DATA (push_data),
    .POP       (RD_EN),
    .POP_DATA  (head),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY)
  );

  assign {head_integral, head_peak, head_baseline, head_sat, head_early, head_tag} = head;

  // Storage survives reset, so the head is masked to present zeros while empty.
  assign OUT_INTEGRAL = EMPTY ? '0 : head_integral;
  assign OUT_PEAK     = EMPTY ? '0 : head_peak;
  assign OUT_BASELINE = EMPTY ? '0 : head_baseline;
  assign OUT_SAT      = EMPTY ? 1'b0 : head_sat;
  assign OUT_EARLY    = EMPTY ? 1'b0 : head_early;
  assign OUT_TAG      = EMPTY ? '0 : head_tag;

endmodule

// File: tb/tb_shwr_summary_buf.sv
module tb_shwr_summary_buf;

  logic        CLK120;
  logic        RESET;
  logic        TRIGGERED;
  logic [18:0] INTEGRAL;
  logic [11:0] PEAK;
  logic [13:0] BASELINE;
  logic        SATURATED;
  logic        RD_EN;
  logic [18:0] OUT_INTEGRAL;
  logic [11:0] OUT_PEAK;
  logic [13:0] OUT_BASELINE;
  logic        OUT_SAT;
  logic        OUT_EARLY;
  logic [7:0]  OUT_TAG;
  logic        EMPTY;
  logic        FULL;
  logic [2:0]  COUNT;
  logic [7:0]  DROPPED;

  int n_checks = 0;
  int n_fail   = 0;

  shwr_summary_buf #(
    .ADC_WIDTH  (12),
    .BASE_WIDTH (14),
    .AREA_WIDTH (19),
    .AREA_BINS  (255),
    .DEPTH_LOG2 (2)
  ) dut (
    .CLK120       (CLK120),
    .RESET        (RESET),
    .TRIGGERED    (TRIGGERED),
    .INTEGRAL     (INTEGRAL),
    .PEAK         (PEAK),
    .BASELINE     (BASELINE),
    .SATURATED    (SATURATED),
    .RD_EN        (RD_EN),
    .OUT_INTEGRAL (OUT_INTEGRAL),
    .OUT_PEAK     (OUT_PEAK),
    .OUT_BASELINE (OUT_BASELINE),
    .OUT_SAT      (OUT_SAT),
    .OUT_EARLY    (OUT_EARLY),
    .OUT_TAG      (OUT_TAG),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .COUNT        (COUNT),
    .DROPPED      (DROPPED)
  );

  initial CLK120 = 1'b0;
  always #5 CLK120 = ~CLK120;

  task automatic tick();
    @(posedge CLK120);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset between edges, then give the FSM one low-TRIGGERED edge to arm.
  task automatic reset_dut();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    tick();
    tick();
  endtask

  // TRIGGERED high for h edges, push edge with optional simultaneous pop.
  task automatic window(input int h, input logic rd_at_push);
    TRIGGERED = 1'b1;
    repeat (h) tick();
    TRIGGERED = 1'b0;
    RD_EN = rd_at_push;
    tick();
    RD_EN = 1'b0;
  endtask

  task automatic pop();
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; TRIGGERED = 1'b0; RD_EN = 1'b0;
    INTEGRAL = '0; PEAK = '0; BASELINE = '0; SATURATED = 1'b0;
    #3;
    chk("rst_empty",   32'(EMPTY), 32'd1);
    chk("rst_full",    32'(FULL), 32'd0);
    chk("rst_count",   32'(COUNT), 32'd0);
    chk("rst_dropped", 32'(DROPPED), 32'd0);
    chk("rst_tag",     32'(OUT_TAG), 32'd0);
    chk("rst_integ",   32'(OUT_INTEGRAL), 32'd0);
    @(posedge CLK120); #1;
    RESET = 1'b0;
    tick(); tick();

    // Single full window, 400 cycles high.
    INTEGRAL = 19'd1000; PEAK = 12'd300; BASELINE = 14'd1000; SATURATED = 1'b0;
    TRIGGERED = 1'b1;
    repeat (259) tick();
    chk("full_not_yet", 32'(EMPTY), 32'd1);
    tick();
    chk("full_empty", 32'(EMPTY), 32'd0);
    chk("full_integ", 32'(OUT_INTEGRAL), 32'd1000);
    chk("full_peak",  32'(OUT_PEAK), 32'd300);
    chk("full_base",  32'(OUT_BASELINE), 32'd1000);
    chk("full_sat",   32'(OUT_SAT), 32'd0);
    chk("full_early", 32'(OUT_EARLY), 32'd0);
    chk("full_tag",   32'(OUT_TAG), 32'd0);
    chk("full_count", 32'(COUNT), 32'd1);
    repeat (140) tick();
    TRIGGERED = 1'b0;
    tick(); tick();
    chk("hold_count", 32'(COUNT), 32'd1);
    pop();
    chk("pop1_empty", 32'(EMPTY), 32'd1);
    chk("pop1_count", 32'(COUNT), 32'd0);

    // Early end after 20 high cycles; upstream holds final value on the fall edge.
    INTEGRAL = 19'd5; PEAK = 12'd12; BASELINE = 14'd900; SATURATED = 1'b1;
    TRIGGERED = 1'b1;
    repeat (19) tick();
    INTEGRAL = 19'd77;
    tick();
    chk("early_not_yet", 32'(EMPTY), 32'd1);
    TRIGGERED = 1'b0;
    tick();
    chk("early_empty", 32'(EMPTY), 32'd0);
    chk("early_integ", 32'(OUT_INTEGRAL), 32'd77);
    chk("early_peak",  32'(OUT_PEAK), 32'd12);
    chk("early_base",  32'(OUT_BASELINE), 32'd900);
    chk("early_sat",   32'(OUT_SAT), 32'd1);
    chk("early_flag",  32'(OUT_EARLY), 32'd1);
    chk("early_tag",   32'(OUT_TAG), 32'd1);
    pop();

    // TRIGGERED falls on the same edge the counter completes: normal completion.
    SATURATED = 1'b0; INTEGRAL = 19'd4242;
    window(259, 1'b0);
    chk("edge_integ", 32'(OUT_INTEGRAL), 32'd4242);
    chk("edge_early", 32'(OUT_EARLY), 32'd0);
    chk("edge_tag",   32'(OUT_TAG), 32'd2);
    tick();
    chk("edge_count", 32'(COUNT), 32'd1);
    pop();

    // Overflow: six windows into a depth-4 FIFO with no reads.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      INTEGRAL = 19'(100 + i);
      window(3, 1'b0);
    end
    chk("ovf_count",   32'(COUNT), 32'd4);
    chk("ovf_full",    32'(FULL), 32'd1);
    chk("ovf_dropped", 32'(DROPPED), 32'd2);
    chk("ovf_head",    32'(OUT_TAG), 32'd0);
    chk("ovf_hinteg",  32'(OUT_INTEGRAL), 32'd100);
    // Push and pop together while FULL: tag 6 lands at the tail.
    INTEGRAL = 19'd606;
    window(3, 1'b1);
    chk("pp_count",   32'(COUNT), 32'd4);
    chk("pp_full",    32'(FULL), 32'd1);
    chk("pp_dropped", 32'(DROPPED), 32'd2);
    chk("pp_head1",   32'(OUT_TAG), 32'd1);
    pop();
    chk("pp_head2", 32'(OUT_TAG), 32'd2);
    pop();
    chk("pp_head3", 32'(OUT_TAG), 32'd3);
    chk("pp_count3", 32'(COUNT), 32'd2);
    pop();
    chk("pp_head6",  32'(OUT_TAG), 32'd6);
    chk("pp_integ6", 32'(OUT_INTEGRAL), 32'd606);
    pop();
    chk("pp_drained", 32'(EMPTY), 32'd1);

    // Reset mid-window with TRIGGERED staying high: no record, no re-arm.
    reset_dut();
    TRIGGERED = 1'b1;
    repeat (101) tick();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    repeat (300) tick();
    chk("rmid_empty", 32'(EMPTY), 32'd1);
    TRIGGERED = 1'b0;
    tick(); tick();
    chk("rmid_count", 32'(COUNT), 32'd0);
    INTEGRAL = 19'd555;
    TRIGGERED = 1'b1;
    repeat (260) tick();
    chk("rmid_tag",   32'(OUT_TAG), 32'd0);
    chk("rmid_integ", 32'(OUT_INTEGRAL), 32'd555);
    chk("rmid_early", 32'(OUT_EARLY), 32'd0);
    TRIGGERED = 1'b0;
    tick();
    pop();

    // Pop while EMPTY, then tag wrap across 256 windows.
    reset_dut();
    pop();
    chk("pe_count", 32'(COUNT), 32'd0);
    chk("pe_empty", 32'(EMPTY), 32'd1);
    for (int i = 0; i < 256; i++) begin
      window(1, 1'b0);
      chk("wrap_tag", 32'(OUT_TAG), 32'(i));
      pop();
    end
    window(1, 1'b0);
    chk("wrap_257", 32'(OUT_TAG), 32'd0);
    chk("wrap_count", 32'(COUNT), 32'd1);

    // DROPPED saturates at 255.
    reset_dut();
    repeat (4) window(1, 1'b0);
    repeat (255) window(1, 1'b0);
    chk("sat_dropped", 32'(DROPPED), 32'd255);
    window(1, 1'b0);
    chk("sat_hold",  32'(DROPPED), 32'd255);
    chk("sat_count", 32'(COUNT), 32'd4);
    chk("sat_head",  32'(OUT_TAG), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
